sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two half-word
// accesses followed by programmable wait states; ready=0 freezes the pipeline meanwhile.
module sram_controller #(
  parameter int unsigned MEM_BASE    = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, DONE} state_t;

  localparam logic [2:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  wcnt, wcnt_nxt;
  logic        is_wr;
  logic [16:0] idx_q;
  logic        req;
  logic [16:0] idx;

  assign req = wr_en | rd_en;
  assign idx = 17'((address - 32'(MEM_BASE)) >> 2);

  // Request type and word index are captured once so later pipeline changes cannot disturb the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wcnt      <= 3'd0;
      is_wr     <= 1'b0;
      idx_q     <= 17'd0;
      read_data <= 32'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state == IDLE && req) begin
        is_wr <= wr_en;
        idx_q <= idx;
      end
      if (state == ACC_LO && !is_wr) read_data[15:0]  <= sram_dq_in;
      if (state == ACC_HI && !is_wr) read_data[31:16] <= sram_dq_in;
    end
  end

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = ACC_LO;
      end
      ACC_LO: begin
        state_nxt = ACC_HI;
        sram_addr = {idx_q, 1'b0};
        if (is_wr) begin
          sram_dq_out = write_data[15:0];
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      ACC_HI: begin
        wcnt_nxt  = 3'd0;
        if (WAIT_CYCLES == 0) state_nxt = DONE;
        else                  state_nxt = WAIT;
        sram_addr = {idx_q, 1'b1};
        if (is_wr) begin
          sram_dq_out = write_data[31:16];
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      WAIT: begin
        wcnt_nxt = wcnt + 3'd1;
        if (wcnt == WAIT_LAST) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
